// File: rtl/imm_pkg.sv
// Shared types, widths and range checks for the immediate packer and its verification model.
package imm_pkg;

    localparam int DATA_W = 8;
    localparam int CODE_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ONE  = 2'd1,
        HI   = 2'd2,
        LO   = 2'd3
    } imm_state_t;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              sign_ex;
        logic              hi_part;
        logic              last;
    } imm_word_t;

    // -4..3: the top six bits are all copies of the sign.
    function automatic logic is_short(input logic [DATA_W-1:0] v);
        return (v[7:2] == 6'b111111) || (v[7:2] == 6'b000000);
    endfunction

    // -32..31: the top three bits are all copies of the sign.
    function automatic logic is_long(input logic [DATA_W-1:0] v);
        return (v[7:5] == 3'b111) || (v[7:5] == 3'b000);
    endfunction

endpackage

// File: rtl/imm_classify.sv
// Combinational range classifier and word generator for one 8-bit constant.
// Short-form encoding is only built when IMM_SHORT_FORM_EN is defined.
module imm_classify
    import imm_pkg::*;
(
    input  logic [DATA_W-1:0] imm,
    output imm_word_t         first_word,
    output logic              is_split,
    output logic [CODE_W-1:0] lo_code
);

    // NOTE: every output gets a default before any branch so no latch is inferred.
    always_comb begin
        first_word = '0;
        is_split   = 1'b0;
        lo_code    = {2'b00, imm[3:0]};
`ifdef IMM_SHORT_FORM_EN
        if (is_short(imm)) begin
            first_word = '{code: {3'b000, imm[2:0]}, sign_ex: 1'b0, hi_part: 1'b0, last: 1'b1};
        end else
`endif
        if (is_long(imm)) begin
            first_word = '{code: imm[5:0], sign_ex: 1'b1, hi_part: 1'b0, last: 1'b1};
        end else begin
            // High half is the value shifted right by four, sign-extended to the code width.
            first_word = '{code: {imm[7], imm[7], imm[7:4]}, sign_ex: 1'b1, hi_part: 1'b1, last: 1'b0};
            is_split   = 1'b1;
        end
    end

endmodule

// File: rtl/imm_packer.sv
// Packs 8-bit constants into one or two 6-bit immediate codes over valid/ready handshakes.
// Optional short-form encoding is enabled with IMM_SHORT_FORM_EN.
module imm_packer
    import imm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] ImmIn,
    input  logic              InValid,
    output logic              InReady,
    output logic [CODE_W-1:0] InstrCode,
    output logic              SignEx,
    output logic              HiPart,
    output logic              Last,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [7:0]        SplitCount
);

    imm_state_t        state_q, state_d;
    imm_word_t         word_q;
    logic [CODE_W-1:0] lo_q;
    logic [7:0]        split_cnt_q;

    imm_word_t         cls_word;
    logic              cls_split;
    logic [CODE_W-1:0] cls_lo;

    logic out_hs;
    logic accept;
    logic load_first;
    logic load_lo;

    imm_classify u_classify (
        .imm        (ImmIn),
        .first_word (cls_word),
        .is_split   (cls_split),
        .lo_code    (cls_lo)
    );

    assign OutValid   = (state_q != IDLE);
    assign out_hs     = OutValid & OutReady;
    assign InReady    = (state_q == IDLE) | (out_hs & word_q.last);
    assign accept     = InValid & InReady;

    assign InstrCode  = word_q.code;
    assign SignEx     = word_q.sign_ex;
    assign HiPart     = word_q.hi_part;
    assign Last       = word_q.last;
    assign SplitCount = split_cnt_q;

    always_comb begin
        state_d    = state_q;
        load_first = 1'b0;
        load_lo    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = cls_split ? HI : ONE;
                    load_first = 1'b1;
                end
            end
            HI: begin
                if (out_hs) begin
                    state_d = LO;
                    load_lo = 1'b1;
                end
            end
            ONE, LO: begin
                if (out_hs) begin
                    if (accept) begin
                        state_d    = cls_split ? HI : ONE;
                        load_first = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            word_q      <= '0;
            lo_q        <= '0;
            split_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_first) begin
                word_q <= cls_word;
                lo_q   <= cls_lo;
            end else if (load_lo) begin
                word_q <= '{code: lo_q, sign_ex: 1'b1, hi_part: 1'b0, last: 1'b1};
            end
            if (accept && cls_split && split_cnt_q != 8'hFF) begin
                split_cnt_q <= split_cnt_q + 8'd1;
            end
        end
    end

endmodule

// File: doc/imm_packer.md
# imm_packer

Sequential inverse of the immediate sign-extender in the 8-bit processor datapath. Accepts 8-bit constants over a valid/ready handshake and emits one or two 6-bit instruction immediate codes with the matching `sign_ex` select. The sign-extender reconstructs the original value from these codes. The block sits between the program loader/assembler front end and instruction memory write logic.

## Interface
- No parameters; all widths fixed by the ISA: 8-bit data, 6-bit code.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ImmIn` in 8: constant to encode.
- `InValid` in 1: `ImmIn` valid.
- `InReady` out 1: block can accept `ImmIn` this cycle.
- `InstrCode` out 6: emitted immediate code.
- `SignEx` out 1: extender select for this word; 1 = long form, 0 = short form.
- `HiPart` out 1: word is the high half of a split constant.
- `Last` out 1: final word for the current constant.
- `OutValid` out 1: output word valid.
- `OutReady` in 1: consumer accepts the word.
- `SplitCount` out 8: number of constants that needed two words; saturating.

## Operation
- Range classes for the input value `v`:
  - Short: `v[7:2]` all equal, i.e. -4..3.
  - Long: `v[7:5]` all equal, i.e. -32..31.
  - Split: anything else.
- Short (only when configured):
  - `InstrCode = {3'b000, v[2:0]}`, `SignEx = 0`, `HiPart = 0`, `Last = 1`.
- Long, and short when not configured:
  - `InstrCode = v[5:0]`, `SignEx = 1`, `HiPart = 0`, `Last = 1`.
- Split emits two words:
  - Word 0: `InstrCode = {v[7], v[7], v[7:4]}`, `SignEx = 1`, `HiPart = 1`, `Last = 0`.
  - Word 1: `InstrCode = {2'b00, v[3:0]}`, `SignEx = 1`, `HiPart = 0`, `Last = 1`.
  - Consumer reconstructs `v = (sext(word0) << 4) | word1[3:0]`.
- FSM states:
  - `IDLE`: no word held.
  - `ONE`: single word held.
  - `HI`: split word 0 held.
  - `LO`: split word 1 held.
- Transitions:
  - `IDLE` on accept goes to `ONE` or `HI`.
  - `HI` on output handshake goes to `LO`.
  - `ONE` or `LO` on output handshake goes to `IDLE`, or directly to `ONE`/`HI` if a new input is accepted in the same cycle.
- `InReady = (state == IDLE) | (OutValid & OutReady & Last)`, giving back-to-back single-word constants at full throughput.
- `SplitCount` increments on every input accept classified as Split. It saturates at 255 and is never cleared except by reset.

## Timing
- Latency: registered output. A word appears on `OutValid` the cycle after input accept.
- Throughput:
  - 1 constant/cycle for single-word constants.
  - Split constants take 2 output cycles.
- `InstrCode`, `SignEx`, `HiPart`, `Last` are held stable while `OutValid & !OutReady`.
- Reset values:
  - State `IDLE`.
  - `OutValid = 0`, `InstrCode = 0`, `SignEx = 0`, `HiPart = 0`, `Last = 0`.
  - `SplitCount = 0`.
  - `InReady = 1` once reset deasserts.
- Reset mid-split: the held word and the pending low half are discarded, with no partial output afterwards.
- `InValid` while `InReady = 0` is ignored. The upstream must hold the value.
- Boundary values:
  - 31 and -32 (0xE0) are Long.
  - 32 (0x20) and -33 (0xDF) are Split.
  - 3 and -4 (0xFC) are Short when configured.

## Configuration
- `IMM_SHORT_FORM_EN` defined:
  - Short-class values emit `SignEx = 0` short-form words.
- `IMM_SHORT_FORM_EN` not defined:
  - Short-class values emit long form.
  - `SignEx` is never 0 on a valid word.
  - Short-class comparison logic is removed.

## Structure
- Shared package `imm_pkg`:
  - FSM state enum.
  - Code width 6 and data width 8 constants.
  - Short/long range-check functions, reused by the verification model.
- One natural sub-module: `imm_classify`, a combinational class and word generator, instantiated once.

## Test plan
- Long: `ImmIn = 0x1F`, `OutReady = 1` -> one word, `InstrCode = 0x1F`, `SignEx = 1`, `Last = 1`.
- Split: `ImmIn = 0x7A` -> word 0 `0x07` with `HiPart = 1`, then word 1 `0x0A` with `Last = 1`; `SplitCount = 1`.
- Negative split: `ImmIn = 0x9C` -> word 0 `0x39`, word 1 `0x0C`; reconstruction gives 0x9C.
- Short:
  - With `IMM_SHORT_FORM_EN`, `ImmIn = 0xFD` -> `InstrCode = 0x05`, `SignEx = 0`.
  - Without the macro -> `0x3D`, `SignEx = 1`.
- Backpressure: hold `OutReady = 0` for 3 cycles during split word 0 -> outputs stable and `InReady = 0`; back-to-back `0x01`, `0x02` with `OutReady = 1` -> one word per cycle.
- Reset asserted while in `LO` -> next cycle `OutValid = 0`; after release `SplitCount = 0` and `InReady = 1`.
